pat_frame_checker: RTL and testbench
====================================

Name: pat_frame_checker

Overview:
- Receive end of the pattern frame stream. Sinks the AXIS frame stream (rows of CYCLES_PER_ROW beats, TLAST on each row's last beat, ROWS_PER_FRAME rows per frame, pattern replicated across the bus).
- Verifies framing and data replication, captures each frame's pattern, and keeps frame and error counters for status readback.
- Sits at the far end of the pattern-generator output path, either in loopback test builds or on the receiving board.

Parameters:
- PATTERN_WIDTH, 32, width of one pattern word.
- INPUT_WIDTH, 32, input bus width. Must be an integer multiple of PATTERN_WIDTH. LANES = INPUT_WIDTH/PATTERN_WIDTH.
- CYCLES_PER_ROW, 4, beats per row. Must be >= 1.
- ROWS_PER_FRAME, 5, rows per frame. Must be >= 1.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- AXIS_IN_TDATA  input  INPUT_WIDTH  frame data.
- AXIS_IN_TVALID  input  1  beat valid.
- AXIS_IN_TLAST  input  1  row end marker.
- AXIS_IN_TREADY  output  1  beat accept.
- clear_status  input  1  single-cycle pulse; clears counters and sticky flags.
- pattern  output  PATTERN_WIDTH  lane 0 of the first beat of the most recent frame.
- frame_done  output  1  one-cycle pulse when a frame's final beat is accepted.
- frame_count  output  32  completed frames; wraps at 2^32.
- error_count  output  32  beats carrying any error; saturates at 0xFFFFFFFF.
- err_lane  output  1  sticky: a lane differed from the frame's captured pattern.
- err_tlast  output  1  sticky: TLAST was early or missing.

Behaviour:
- Reset (async assert, sync release): all outputs 0, including AXIS_IN_TREADY. State = IDLE, cycle_idx = 0, row_idx = 0.
- AXIS_IN_TREADY is a register driven to 1 on the first clock after reset deasserts. A beat is accepted when TVALID & TREADY on a rising edge.
- State machine:
  - IDLE, on accept: capture lane 0 into `pattern`. Check every lane against lane 0. Process framing for this beat (below). Go to IN_FRAME, unless the frame completes on this beat (CYCLES_PER_ROW=ROWS_PER_FRAME=1), in which case stay in IDLE.
  - IN_FRAME, on accept: check every lane against the registered `pattern`. Process framing.
- Framing per accepted beat, where expected_last = (cycle_idx == CYCLES_PER_ROW-1):
  - TLAST=1 and expected_last=0: early TLAST. Set tlast error. Row ends on this beat.
  - TLAST=0 and expected_last=1: missing TLAST. Set tlast error. Row still ends on this beat.
  - Row end: cycle_idx <= 0. If row_idx == ROWS_PER_FRAME-1, then row_idx <= 0, frame_done pulses next cycle, frame_count increments, and state goes to IDLE. Otherwise row_idx increments.
  - Not row end: cycle_idx increments.
- Error accounting: a beat with a lane and/or tlast error increments error_count once (saturating) and sets the matching sticky flags. Flags and counter update one cycle after the accepting edge.
- All status outputs are registered. frame_done and frame_count update on the same cycle.
- clear_status: zeroes frame_count, error_count, err_lane and err_tlast. It does not affect state, cycle_idx, row_idx or `pattern`.
  - If clear_status coincides with an error beat or frame completion, the clear wins on counters and flags; that beat's events are dropped.
  - frame_done still pulses.
- No accept on a cycle: no state change.
- TVALID gaps mid-row are legal and are not errors.
- Reset mid-frame: the partial frame is discarded. The next accepted beat is treated as a frame start.
- Counters use unsigned 32-bit arithmetic. cycle_idx and row_idx are $clog2-sized, with a minimum of 1 bit.

Optional Feature:
- Macro PATCHK_SEQ_CHECK_EN.
- Defined:
  - Adds output err_seq (1 bit, sticky, reset 0, cleared by clear_status).
  - From the second frame after reset or clear_status onward, the frame-start pattern must equal the previous frame's pattern + 1, mod 2^PATTERN_WIDTH.
  - On mismatch: set err_seq and count the beat in error_count (once per beat, combined with other errors).
  - The first frame after reset or clear only seeds the reference.
- Not defined: no err_seq port, no sequence logic.

Test Plan:
- Nominal: 3 frames of 20 beats, patterns 0xA5A5A5A5, 0x00000001, 0xFFFFFFFF, TLAST on beats 3, 7, 11, 15, 19; continuous TVALID -> frame_done pulses 3 times, frame_count=3, error_count=0, flags 0, pattern=0xFFFFFFFF.
- Lane mismatch, INPUT_WIDTH=64: beat 6 of frame has upper lane 0x12345678, lower lane 0xA5A5A5A5 -> err_lane=1, error_count=1, frame still completes, frame_count=1.
- Early TLAST on beat 1 of row 0 -> err_tlast=1, error_count=1. Row ends; the frame then completes after 4 more full rows (18 beats total), frame_count=1.
- Missing TLAST on beat 3 -> err_tlast=1, error_count=1, row boundary kept at beat 3, frame ends at beat 19.
- Backpressure: TVALID toggling randomly 50% plus reset asserted after 7 beats, then a clean 20-beat frame -> frame_count=1, no errors. Also assert clear_status in the same cycle as a frame's last beat -> frame_count=0, frame_done still pulses.
- With PATCHK_SEQ_CHECK_EN: patterns 5, 6, 8 -> err_seq=1 at the third frame, error_count=1. Patterns 0xFFFFFFFF then 0 -> no error.

Source files
------------

// File: rtl/pat_frame_checker.sv
// Receive-side checker for the replicated-pattern AXIS frame stream: verifies framing and lane replication,
// captures each frame's pattern and keeps frame/error status. Optional macro PATCHK_SEQ_CHECK_EN adds err_seq.
module pat_frame_checker #(
    parameter int PATTERN_WIDTH  = 32,
    parameter int INPUT_WIDTH    = 32,
    parameter int CYCLES_PER_ROW = 4,
    parameter int ROWS_PER_FRAME = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [INPUT_WIDTH-1:0]   AXIS_IN_TDATA,
    input  logic                     AXIS_IN_TVALID,
    input  logic                     AXIS_IN_TLAST,
    output logic                     AXIS_IN_TREADY,
    input  logic                     clear_status,
    output logic [PATTERN_WIDTH-1:0] pattern,
    output logic                     frame_done,
    output logic [31:0]              frame_count,
    output logic [31:0]              error_count,
    output logic                     err_lane,
`ifdef PATCHK_SEQ_CHECK_EN
    output logic                     err_seq,
`endif
    output logic                     err_tlast
);

    localparam int LANES = INPUT_WIDTH / PATTERN_WIDTH;
    localparam int CW    = (CYCLES_PER_ROW > 1) ? $clog2(CYCLES_PER_ROW) : 1;
    localparam int RW    = (ROWS_PER_FRAME > 1) ? $clog2(ROWS_PER_FRAME) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(CYCLES_PER_ROW - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS_PER_FRAME - 1);

    typedef enum logic {
        IDLE,
        IN_FRAME
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cycle_idx_q, cycle_idx_d;
    logic [RW-1:0]          row_idx_q, row_idx_d;
    logic [PATTERN_WIDTH-1:0] pattern_q, pattern_d;
    logic                   tready_q, tready_d;
    logic                   frame_done_q, frame_done_d;
    logic [31:0]            frame_count_q, frame_count_d;
    logic [31:0]            error_count_q, error_count_d;
    logic                   err_lane_q, err_lane_d;
    logic                   err_tlast_q, err_tlast_d;
`ifdef PATCHK_SEQ_CHECK_EN
    logic                   err_seq_q, err_seq_d;
    logic                   seq_valid_q, seq_valid_d;
`endif

    logic                   accept;
    logic [PATTERN_WIDTH-1:0] lane0;
    logic [PATTERN_WIDTH-1:0] ref_pat;
    logic                   lane_err;
    logic                   expected_last;
    logic                   tlast_err;
    logic                   row_end;
    logic                   frame_end;
    logic                   seq_err;
    logic                   beat_err;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_d       = state_q;
        cycle_idx_d   = cycle_idx_q;
        row_idx_d     = row_idx_q;
        pattern_d     = pattern_q;
        tready_d      = 1'b1;
        frame_done_d  = 1'b0;
        frame_count_d = frame_count_q;
        error_count_d = error_count_q;
        err_lane_d    = err_lane_q;
        err_tlast_d   = err_tlast_q;
`ifdef PATCHK_SEQ_CHECK_EN
        err_seq_d     = err_seq_q;
        seq_valid_d   = seq_valid_q;
`endif

        accept  = AXIS_IN_TVALID && tready_q;
        lane0   = AXIS_IN_TDATA[PATTERN_WIDTH-1:0];
        // A frame's first beat is checked against itself; later beats against the captured pattern.
        ref_pat = (state_q == IDLE) ? lane0 : pattern_q;

        lane_err = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (AXIS_IN_TDATA[i*PATTERN_WIDTH +: PATTERN_WIDTH] != ref_pat) begin
                lane_err = 1'b1;
            end
        end

        expected_last = (cycle_idx_q == CYC_LAST);
        tlast_err     = (AXIS_IN_TLAST != expected_last);
        row_end       = AXIS_IN_TLAST || expected_last;
        frame_end     = row_end && (row_idx_q == ROW_LAST);

        seq_err = 1'b0;
`ifdef PATCHK_SEQ_CHECK_EN
        seq_err = (state_q == IDLE) && seq_valid_q && (lane0 != pattern_q + PATTERN_WIDTH'(1));
`endif
        beat_err = lane_err || tlast_err || seq_err;

        if (accept) begin
            if (state_q == IDLE) begin
                pattern_d = lane0;
`ifdef PATCHK_SEQ_CHECK_EN
                seq_valid_d = 1'b1;
`endif
            end

            if (row_end) begin
                cycle_idx_d = '0;
                if (frame_end) begin
                    row_idx_d     = '0;
                    frame_done_d  = 1'b1;
                    frame_count_d = frame_count_q + 32'd1;
                    state_d       = IDLE;
                end else begin
                    row_idx_d = row_idx_q + RW'(1);
                    state_d   = IN_FRAME;
                end
            end else begin
                cycle_idx_d = cycle_idx_q + CW'(1);
                state_d     = IN_FRAME;
            end

            if (beat_err) begin
                if (error_count_q != 32'hFFFF_FFFF) begin
                    error_count_d = error_count_q + 32'd1;
                end
                err_lane_d  = err_lane_q || lane_err;
                err_tlast_d = err_tlast_q || tlast_err;
`ifdef PATCHK_SEQ_CHECK_EN
                err_seq_d   = err_seq_q || seq_err;
`endif
            end
        end

        // Clear overrides this cycle's events on status; framing and frame_done are untouched.
        if (clear_status) begin
            frame_count_d = '0;
            error_count_d = '0;
            err_lane_d    = 1'b0;
            err_tlast_d   = 1'b0;
`ifdef PATCHK_SEQ_CHECK_EN
            err_seq_d     = 1'b0;
            seq_valid_d   = 1'b0;
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cycle_idx_q   <= '0;
            row_idx_q     <= '0;
            pattern_q     <= '0;
            tready_q      <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
            error_count_q <= '0;
            err_lane_q    <= 1'b0;
            err_tlast_q   <= 1'b0;
`ifdef PATCHK_SEQ_CHECK_EN
            err_seq_q     <= 1'b0;
            seq_valid_q   <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cycle_idx_q   <= cycle_idx_d;
            row_idx_q     <= row_idx_d;
            pattern_q     <= pattern_d;
            tready_q      <= tready_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
            error_count_q <= error_count_d;
            err_lane_q    <= err_lane_d;
            err_tlast_q   <= err_tlast_d;
`ifdef PATCHK_SEQ_CHECK_EN
            err_seq_q     <= err_seq_d;
            seq_valid_q   <= seq_valid_d;
`endif
        end
    end

    assign AXIS_IN_TREADY = tready_q;
    assign pattern        = pattern_q;
    assign frame_done     = frame_done_q;
    assign frame_count    = frame_count_q;
    assign error_count    = error_count_q;
    assign err_lane       = err_lane_q;
    assign err_tlast      = err_tlast_q;
`ifdef PATCHK_SEQ_CHECK_EN
    assign err_seq        = err_seq_q;
`endif

endmodule

// File: tb/tb_pat_frame_checker.sv
// Scoreboard bench for pat_frame_checker (2 lanes of 32 bits, 4x5 frame); a beat-level model pushes
// the expected status for every completed frame, and a monitor pops it on each frame_done pulse.
module tb_pat_frame_checker;

    localparam int PW = 32;
    localparam int IW = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic [IW-1:0] tdata;
    logic          tvalid;
    logic          tlast;
    logic          tready;
    logic          clear_status;
    logic [PW-1:0] pattern;
    logic          frame_done;
    logic [31:0]   frame_count;
    logic [31:0]   error_count;
    logic          err_lane;
    logic          err_tlast;
`ifdef PATCHK_SEQ_CHECK_EN
    logic          err_seq;
`endif

    always #5 clk = ~clk;

    pat_frame_checker #(
        .PATTERN_WIDTH (PW),
        .INPUT_WIDTH   (IW),
        .CYCLES_PER_ROW(4),
        .ROWS_PER_FRAME(5)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .AXIS_IN_TDATA (tdata),
        .AXIS_IN_TVALID(tvalid),
        .AXIS_IN_TLAST (tlast),
        .AXIS_IN_TREADY(tready),
        .clear_status  (clear_status),
        .pattern       (pattern),
        .frame_done    (frame_done),
        .frame_count   (frame_count),
        .error_count   (error_count),
        .err_lane      (err_lane),
`ifdef PATCHK_SEQ_CHECK_EN
        .err_seq       (err_seq),
`endif
        .err_tlast     (err_tlast)
    );

    typedef struct {
        logic [31:0] pat;
        logic [31:0] fc;
        logic [31:0] ec;
        logic        el;
        logic        et;
        logic        es;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    int n_tests = 0;
    int n_fail  = 0;
    bit gap_en  = 1'b0;

    // Behavioural reference of the receiver
    bit          m_in_frame;
    int          m_cyc;
    int          m_row;
    logic [31:0] m_pat, m_prev, m_fc, m_ec;
    logic        m_el, m_et, m_es, m_seq_valid;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_in_frame = 0; m_cyc = 0; m_row = 0;
        m_pat = '0; m_prev = '0; m_fc = '0; m_ec = '0;
        m_el = 0; m_et = 0; m_es = 0; m_seq_valid = 0;
    endtask

    task automatic model_clear();
        m_fc = '0; m_ec = '0; m_el = 0; m_et = 0; m_es = 0; m_seq_valid = 0;
    endtask

    task automatic model_accept(input logic [63:0] data, input logic last, input logic clr);
        logic [31:0] lane0, refp;
        logic lerr, terr, serr, exp_last, row_end, frame_end, start;
        exp_t e;
        lane0 = data[31:0];
        start = !m_in_frame;
        refp  = start ? lane0 : m_pat;
        lerr  = (data[63:32] != refp) || (data[31:0] != refp);
        serr  = 1'b0;
`ifdef PATCHK_SEQ_CHECK_EN
        if (start) begin
            serr = m_seq_valid && (lane0 != m_prev + 32'd1);
            m_prev = lane0;
            m_seq_valid = 1'b1;
        end
`endif
        if (start) m_pat = lane0;
        exp_last  = (m_cyc == 3);
        terr      = (last != exp_last);
        row_end   = last || exp_last;
        frame_end = row_end && (m_row == 4);
        if (row_end) begin
            m_cyc = 0;
            m_row = frame_end ? 0 : m_row + 1;
        end else begin
            m_cyc++;
        end
        m_in_frame = !frame_end;
        if (clr) begin
            model_clear();
        end else begin
            if (lerr || terr || serr) begin
                if (m_ec != 32'hFFFF_FFFF) m_ec++;
                m_el |= lerr; m_et |= terr; m_es |= serr;
            end
            if (frame_end) m_fc++;
        end
        if (frame_end) begin
            e.pat = m_pat; e.fc = m_fc; e.ec = m_ec; e.el = m_el; e.et = m_et; e.es = m_es;
            sb_q.push_back(e);
        end
    endtask

    // Inputs change #1 after a rising edge; outputs are sampled on falling edges.
    task automatic send_beat(input logic [63:0] data, input logic last, input logic clr);
        int waited = 0;
        if (gap_en) begin
            while ($urandom_range(0, 1) == 0) begin
                tvalid = 1'b0;
                @(posedge clk); #1;
            end
        end
        tvalid = 1'b1; tdata = data; tlast = last;
        while (!tready && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!tready) begin
            check("tready_timeout", 64'(tready), 64'd1);
            tvalid = 1'b0;
            return;
        end
        clear_status = clr;
        @(posedge clk); #1;
        model_accept(data, last, clr);
        tvalid = 1'b0; tlast = 1'b0; clear_status = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] pat, input int bad_beat, input int early_beat,
                              input int miss_beat, input int clr_beat);
        int rows = 0, cyc = 0, b = 0;
        logic [63:0] d;
        logic l;
        while (rows < 5 && b < 64) begin
            d = {pat, pat};
            if (b == bad_beat) d[63:32] = 32'h1234_5678;
            l = (cyc == 3);
            if (b == early_beat) l = 1'b1;
            if (b == miss_beat)  l = 1'b0;
            send_beat(d, l, b == clr_beat);
            if (cyc == 3 || b == early_beat) begin
                rows++;
                cyc = 0;
            end else begin
                cyc++;
            end
            b++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; tvalid = 1'b0; tlast = 1'b0; clear_status = 1'b0; tdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_tready", 64'(tready), 64'd0);
        check("rst_pattern", 64'(pattern), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        check("rst_frame_count", 64'(frame_count), 64'd0);
        check("rst_error_count", 64'(error_count), 64'd0);
        check("rst_flags", 64'({err_lane, err_tlast}), 64'd0);
`ifdef PATCHK_SEQ_CHECK_EN
        check("rst_err_seq", 64'(err_seq), 64'd0);
`endif
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic clear_pulse();
        clear_status = 1'b1;
        @(posedge clk); #1;
        clear_status = 1'b0;
        model_clear();
    endtask

    task automatic check_status(input string tag);
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_pattern"}, 64'(pattern), 64'(m_pat));
        check({tag, "_frame_count"}, 64'(frame_count), 64'(m_fc));
        check({tag, "_error_count"}, 64'(error_count), 64'(m_ec));
        check({tag, "_err_lane"}, 64'(err_lane), 64'(m_el));
        check({tag, "_err_tlast"}, 64'(err_tlast), 64'(m_et));
`ifdef PATCHK_SEQ_CHECK_EN
        check({tag, "_err_seq"}, 64'(err_seq), 64'(m_es));
`endif
    endtask

    always @(negedge clk) begin
        if (!reset && frame_done) begin
            if (sb_q.size() == 0) begin
                check("frame_done_spurious", 64'd1, 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("fd_pattern", 64'(pattern), 64'(mon_e.pat));
                check("fd_frame_count", 64'(frame_count), 64'(mon_e.fc));
                check("fd_error_count", 64'(error_count), 64'(mon_e.ec));
                check("fd_err_lane", 64'(err_lane), 64'(mon_e.el));
                check("fd_err_tlast", 64'(err_tlast), 64'(mon_e.et));
`ifdef PATCHK_SEQ_CHECK_EN
                check("fd_err_seq", 64'(err_seq), 64'(mon_e.es));
`endif
            end
        end
    end

    initial begin
        reset = 1'b1; tvalid = 1'b0; tlast = 1'b0; clear_status = 1'b0; tdata = '0;
        model_reset();
        #1;
        do_reset();
        check("tready_after_reset", 64'(tready), 64'd1);

        // Nominal frames, continuous valid
        send_frame(32'hA5A5_A5A5, -1, -1, -1, -1);
        send_frame(32'h0000_0001, -1, -1, -1, -1);
        send_frame(32'hFFFF_FFFF, -1, -1, -1, -1);
        check_status("nominal");
        check("nominal_fc_abs", 64'(frame_count), 64'd3);

        // Upper lane corrupted on beat 6
        do_reset();
        send_frame(32'hA5A5_A5A5, 6, -1, -1, -1);
        check_status("lane");
        check("lane_err_abs", 64'({err_lane, error_count[3:0]}), 64'h11);

        // Early TLAST on beat 1 of row 0 (18-beat frame)
        do_reset();
        send_frame(32'h0000_0011, -1, 1, -1, -1);
        check_status("early");
        check("early_abs", 64'({err_tlast, frame_count[3:0], error_count[3:0]}), 64'h111);

        // Missing TLAST on beat 3
        do_reset();
        send_frame(32'h0000_0022, -1, -1, 3, -1);
        check_status("missing");

        // Backpressure, reset mid-frame, then clean frame; then clear on final beat
        do_reset();
        gap_en = 1'b1;
        for (int b = 0; b < 7; b++) send_beat({2{32'h0000_0033}}, (b % 4) == 3, 1'b0);
        do_reset();
        send_frame(32'h0000_0044, -1, -1, -1, -1);
        check_status("backpressure");
        check("bp_fc_abs", 64'(frame_count), 64'd1);
        send_frame(32'h0000_0055, -1, -1, -1, 19);
        check_status("clear_last");
        check("clear_fc_abs", 64'(frame_count), 64'd0);
        gap_en = 1'b0;

        // Pattern sequence 5, 6, 8 then wrap FFFFFFFF -> 0 after a clear
        do_reset();
        send_frame(32'd5, -1, -1, -1, -1);
        send_frame(32'd6, -1, -1, -1, -1);
        send_frame(32'd8, -1, -1, -1, -1);
        check_status("seq");
        clear_pulse();
        send_frame(32'hFFFF_FFFF, -1, -1, -1, -1);
        send_frame(32'h0000_0000, -1, -1, -1, -1);
        check_status("seq_wrap");

        repeat (3) @(posedge clk);
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
